// File: rtl/mem_pkg.sv
// Shared encodings for the port-B memory interface and the load/store initiator FSM.
// Pure declarations: no logic, no latency, no flow control.
// Imported by lsu_mem_initiator and load_extend.
package mem_pkg;

    localparam logic [1:0] MEMOP_IDLE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } lsuState_t;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        return ((size == SIZE_HALF) && addrLo[0]) || ((size == SIZE_WORD) && (addrLo != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified load data by access size.
// Latency: purely combinational.
// Backpressure: none.
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        dout = din;
        case (size)
            SIZE_BYTE: dout = {{24{isSigned & din[7]}}, din[7:0]};
            SIZE_HALF: dout = {{16{isSigned & din[15]}}, din[15:0]};
            default:   dout = din;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator driving memory port B for the execute stage, one transaction at a time.
// Latency: request in cycle 0, ISSUE in cycle 1, earliest response in cycle 3; alignment errors answer in cycle 1.
// Backpressure: req_ready only in IDLE; a response is held until rsp_ready.
module lsu_mem_initiator
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_err_code,
    output logic [31:0] m_alu,
    output logic [31:0] m_din,
    output logic [1:0]  m_memOp,
    output logic [1:0]  m_memSize,
    input  logic [31:0] m_doutB,
    input  logic        m_readValidB,
    input  logic        m_ready,
    input  logic        m_busErr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsuState_t        state;
    logic             reqStoreQ;
    logic [1:0]       reqSizeQ;
    logic             reqSignedQ;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic [31:0]      loadExt;
    logic             memDone;
    logic             reqBad;

    load_extend uLoadExtend (
        .size     (reqSizeQ),
        .isSigned (reqSignedQ),
        .din      (m_doutB),
        .dout     (loadExt)
    );

    // Stores finish on m_ready, loads on read data valid; both sampled in the same cycle.
    assign memDone     = reqStoreQ ? m_ready : m_readValidB;
    assign reqBad      = (req_size == SIZE_ILLEGAL) ||
                         (CHECK_ALIGN && isMisaligned(req_size, req_addr[1:0]));
    assign waitCntNext = waitCnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_code <= ERR_NONE;
            m_alu        <= '0;
            m_din        <= '0;
            m_memOp      <= MEMOP_IDLE;
            m_memSize    <= SIZE_BYTE;
            waitCnt      <= '0;
            reqStoreQ    <= 1'b0;
            reqSizeQ     <= SIZE_BYTE;
            reqSignedQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        reqStoreQ  <= req_store;
                        reqSizeQ   <= req_size;
                        reqSignedQ <= req_signed;
                        req_ready  <= 1'b0;
                        if (reqBad) begin
                            // Rejected locally: the memory never sees this access.
                            state        <= RESP;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= '0;
                            rsp_err      <= 1'b1;
                            rsp_err_code <= ERR_ALIGN;
                        end else begin
                            state     <= ISSUE;
                            m_alu     <= req_addr;
                            m_din     <= req_wdata;
                            m_memSize <= req_size;
                            m_memOp   <= req_store ? MEMOP_STORE : MEMOP_LOAD;
                        end
                    end
                end
                ISSUE: begin
                    if (m_busErr) begin
                        state        <= RESP;
                        m_memOp      <= MEMOP_IDLE;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_err      <= 1'b1;
                        rsp_err_code <= ERR_BUS;
                    end else begin
                        state   <= WAIT;
                        waitCnt <= '0;
                    end
                end
                WAIT: begin
                    if (memDone) begin
                        state        <= RESP;
                        m_memOp      <= MEMOP_IDLE;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= reqStoreQ ? 32'd0 : loadExt;
                        rsp_err      <= 1'b0;
                        rsp_err_code <= ERR_NONE;
                    end else if (waitCntNext == CNT_W'(TIMEOUT_CYCLES)) begin
                        state        <= RESP;
                        waitCnt      <= waitCntNext;
                        m_memOp      <= MEMOP_IDLE;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_err      <= 1'b1;
                        rsp_err_code <= ERR_TIMEOUT;
                    end else begin
                        waitCnt <= waitCntNext;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    m_memOp   <= MEMOP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed vector bench for lsu_mem_initiator with a hand-driven port-B memory.
module tb_lsu_mem_initiator;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_err_code;
    logic [31:0] m_alu;
    logic [31:0] m_din;
    logic [1:0]  m_memOp;
    logic [1:0]  m_memSize;
    logic [31:0] m_doutB = '0;
    logic        m_readValidB = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_busErr = 1'b0;

    int nCmp = 0;
    int nBad = 0;
    int cycCnt = 0;

    lsu_mem_initiator #(.TIMEOUT_CYCLES(64), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_err_code(rsp_err_code),
        .m_alu(m_alu), .m_din(m_din), .m_memOp(m_memOp), .m_memSize(m_memSize),
        .m_doutB(m_doutB), .m_readValidB(m_readValidB), .m_ready(m_ready), .m_busErr(m_busErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycCnt <= cycCnt + 1;

    typedef struct {
        string       name;
        logic        store;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          delay;   // idle WAIT cycles before completion; -1 = never completes
        logic        busErr;
        logic        issue;
        int          hold;    // cycles rsp_ready stays low once rsp_valid is seen
        logic [31:0] expRdata;
        logic [1:0]  expCode;
        int          expLat;  // cycle index of first rsp_valid, acceptance = cycle 0
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v);
        int accCyc;
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = v.store;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        chk({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        accCyc = cycCnt;
        if (v.issue) begin
            @(negedge clk);
            chk({v.name, " issue memOp"}, 32'(m_memOp), v.store ? 32'(MEMOP_STORE) : 32'(MEMOP_LOAD));
            chk({v.name, " issue alu"}, m_alu, v.addr);
            chk({v.name, " issue memSize"}, 32'(m_memSize), 32'(v.size));
            if (v.store) chk({v.name, " issue din"}, m_din, v.wdata);
            m_busErr = v.busErr;
            @(posedge clk);
            #1;
            m_busErr = 1'b0;
            if (!v.busErr) begin
                chk({v.name, " wait memOp held"}, 32'(m_memOp), v.store ? 32'(MEMOP_STORE) : 32'(MEMOP_LOAD));
                chk({v.name, " wait alu held"}, m_alu, v.addr);
                if (v.delay >= 0) begin
                    for (int i = 0; i < v.delay; i++) begin
                        @(posedge clk);
                        #1;
                    end
                    m_doutB = v.mdata;
                    if (v.store) m_ready = 1'b1;
                    else m_readValidB = 1'b1;
                    @(posedge clk);
                    #1;
                    m_ready = 1'b0;
                    m_readValidB = 1'b0;
                end
            end
        end
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            nCmp++;
            nBad++;
            $display("FAIL %s rsp_valid: never asserted within 200 cycles", v.name);
            return;
        end
        chk({v.name, " latency"}, 32'(cycCnt - accCyc + 1), 32'(v.expLat));
        chk({v.name, " rdata"}, rsp_rdata, v.expRdata);
        chk({v.name, " err"}, 32'(rsp_err), 32'(v.expCode != ERR_NONE));
        chk({v.name, " err_code"}, 32'(rsp_err_code), 32'(v.expCode));
        chk({v.name, " memOp idle at rsp"}, 32'(m_memOp), 32'(MEMOP_IDLE));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({v.name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({v.name, " hold rdata"}, rsp_rdata, v.expRdata);
            chk({v.name, " hold err_code"}, 32'(rsp_err_code), 32'(v.expCode));
            chk({v.name, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        chk({v.name, " req_ready in resp"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({v.name, " rsp_valid dropped"}, 32'(rsp_valid), 32'd0);
        chk({v.name, " req_ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        //        name        st   size        sgn   addr          wdata         mdata         dly bus  iss  hold expRdata      code         lat
        vecs.push_back('{"ldw",     1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1,  1'b0, 1'b1, 5, 32'hDEADBEEF, ERR_NONE,    4});
        vecs.push_back('{"ldb_s",   1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0,        32'h00000080, 0,  1'b0, 1'b1, 0, 32'hFFFFFF80, ERR_NONE,    3});
        vecs.push_back('{"ldb_u",   1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0,        32'h00000080, 0,  1'b0, 1'b1, 0, 32'h00000080, ERR_NONE,    3});
        vecs.push_back('{"ldb_s+",  1'b0, SIZE_BYTE, 1'b1, 32'h001, 32'h0,        32'h0000007F, 0,  1'b0, 1'b1, 0, 32'h0000007F, ERR_NONE,    3});
        vecs.push_back('{"ldh_s",   1'b0, SIZE_HALF, 1'b1, 32'h100, 32'h0,        32'h00008001, 2,  1'b0, 1'b1, 0, 32'hFFFF8001, ERR_NONE,    5});
        vecs.push_back('{"ldh_u",   1'b0, SIZE_HALF, 1'b0, 32'h102, 32'h0,        32'h0000F00D, 0,  1'b0, 1'b1, 0, 32'h0000F00D, ERR_NONE,    3});
        vecs.push_back('{"sth",     1'b1, SIZE_HALF, 1'b0, 32'h202, 32'h00001234, 32'hFFFFFFFF, 1,  1'b0, 1'b1, 0, 32'h0,        ERR_NONE,    4});
        vecs.push_back('{"stb",     1'b1, SIZE_BYTE, 1'b0, 32'h105, 32'h000000AB, 32'h12345678, 0,  1'b0, 1'b1, 0, 32'h0,        ERR_NONE,    3});
        vecs.push_back('{"stw",     1'b1, SIZE_WORD, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0,        2,  1'b0, 1'b1, 2, 32'h0,        ERR_NONE,    5});
        vecs.push_back('{"ldw_mis", 1'b0, SIZE_WORD, 1'b0, 32'h101, 32'h0,        32'h0,        0,  1'b0, 1'b0, 0, 32'h0,        ERR_ALIGN,   1});
        vecs.push_back('{"ldw_mis2",1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0,        32'h0,        0,  1'b0, 1'b0, 0, 32'h0,        ERR_ALIGN,   1});
        vecs.push_back('{"sth_mis", 1'b1, SIZE_HALF, 1'b0, 32'h201, 32'h5555,     32'h0,        0,  1'b0, 1'b0, 0, 32'h0,        ERR_ALIGN,   1});
        vecs.push_back('{"size11",  1'b0, 2'b11,     1'b0, 32'h100, 32'h0,        32'h0,        0,  1'b0, 1'b0, 0, 32'h0,        ERR_ALIGN,   1});
        vecs.push_back('{"buserr",  1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0,        32'h0,        0,  1'b1, 1'b1, 0, 32'h0,        ERR_BUS,     2});
        vecs.push_back('{"last_ok", 1'b0, SIZE_WORD, 1'b0, 32'h600, 32'h0,        32'h0000005A, 63, 1'b0, 1'b1, 0, 32'h0000005A, ERR_NONE,    66});
        vecs.push_back('{"timeout", 1'b0, SIZE_WORD, 1'b0, 32'h700, 32'h0,        32'h0,        -1, 1'b0, 1'b1, 0, 32'h0,        ERR_TIMEOUT, 66});

        // Reset state, sampled while reset is still low.
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst rsp_err_code", 32'(rsp_err_code), 32'd0);
        chk("rst m_memOp", 32'(m_memOp), 32'd0);
        chk("rst m_alu", m_alu, 32'd0);
        chk("rst m_din", m_din, 32'd0);
        chk("rst m_memSize", 32'(m_memSize), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

        // Reset pulsed while a load sits in WAIT: abort at once, no response afterwards.
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_size  = SIZE_WORD;
        req_signed = 1'b0;
        req_addr  = 32'h500;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort memOp in wait", 32'(m_memOp), 32'(MEMOP_LOAD));
        #2;
        reset = 1'b0;
        #1;
        chk("abort memOp", 32'(m_memOp), 32'(MEMOP_IDLE));
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        m_doutB = 32'h11111111;
        m_readValidB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no rsp", 32'(rsp_valid), 32'd0);
            chk("abort memOp stays idle", 32'(m_memOp), 32'(MEMOP_IDLE));
        end
        m_readValidB = 1'b0;

        // Normal traffic resumes after the abort.
        runVec(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
